// File: rtl/mc_ctrl.sv
// Control FSM for a multi-cycle MIPS-subset datapath: decodes IR and drives
// per-cycle enables and mux selects for lw, sw, R-type, beq and j.
module mc_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ir_data,
  input  logic        zero,
  output logic        write_pc,
  output logic        iord,
  output logic        write_mem,
  output logic        write_dr,
  output logic        write_ir,
  output logic        memtoreg,
  output logic        regdst,
  output logic [1:0]  pcsource,
  output logic        write_c,
  output logic [1:0]  alu_ctrl,
  output logic        alu_srcA,
  output logic [1:0]  alu_srcB,
  output logic        write_a,
  output logic        write_b,
  output logic        write_reg,
  output logic [3:0]  state,
  output logic [3:0]  insn_type,
  output logic [3:0]  insn_code,
  output logic [2:0]  insn_stage
);

  typedef enum logic [3:0] {
    S_IF = 4'd0, S_ID = 4'd1, S_MADDR = 4'd2, S_MRD = 4'd3, S_LWWB = 4'd4,
    S_MWR = 4'd5, S_REX = 4'd6, S_RWB = 4'd7, S_BEQ = 4'd8, S_J = 4'd9
  } state_t;

  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B,
                         OP_BEQ = 6'h04, OP_J = 6'h02;
  localparam logic [3:0] T_ILL = 4'd0, T_R = 4'd1, T_LW = 4'd2,
                         T_SW = 4'd3, T_BEQ = 4'd4, T_J = 4'd5;

  // Power-up value lets the FSM start fetching without a reset pulse.
  state_t state_q = S_IF;
  state_t state_d;

  logic [5:0] opcode, funct;
  logic [3:0] dec_type, dec_code;
  logic       unused_ir_bits;

  assign opcode         = ir_data[31:26];
  assign funct          = ir_data[5:0];
  assign unused_ir_bits = ^ir_data[25:6];

  always_comb begin
    dec_type = T_ILL;
    dec_code = 4'd0;
    case (opcode)
      OP_R: begin
        dec_type = T_R;
        case (funct)
          6'h20:   dec_code = 4'd1;
          6'h22:   dec_code = 4'd2;
          6'h24:   dec_code = 4'd3;
          6'h25:   dec_code = 4'd4;
          6'h27:   dec_code = 4'd5;
          6'h2A:   dec_code = 4'd6;
          default: dec_code = 4'd0;
        endcase
      end
      OP_LW:   dec_type = T_LW;
      OP_SW:   dec_type = T_SW;
      OP_BEQ:  dec_type = T_BEQ;
      OP_J:    dec_type = T_J;
      default: dec_type = T_ILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IF;
      insn_type <= 4'd0;
      insn_code <= 4'd0;
    end else begin
      state_q <= state_d;
      // Decode is captured once per instruction, at the end of ID.
      if (state_q == S_ID) begin
        insn_type <= dec_type;
        insn_code <= dec_code;
      end
    end
  end

  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        case (dec_type)
          T_LW, T_SW: state_d = S_MADDR;
          T_R:        state_d = S_REX;
          T_BEQ:      state_d = S_BEQ;
          T_J:        state_d = S_J;
          default:    state_d = S_IF;
        endcase
      end
      S_MADDR: begin
        if (dec_type == T_LW)      state_d = S_MRD;
        else if (dec_type == T_SW) state_d = S_MWR;
        else                       state_d = S_IF;
      end
      S_MRD:   state_d = S_LWWB;
      S_REX:   state_d = S_RWB;
      default: state_d = S_IF;
    endcase
  end

  always_comb begin
    write_pc  = 1'b0;
    iord      = 1'b0;
    write_mem = 1'b0;
    write_dr  = 1'b0;
    write_ir  = 1'b0;
    memtoreg  = 1'b0;
    regdst    = 1'b0;
    pcsource  = 2'b00;
    write_c   = 1'b0;
    alu_ctrl  = 2'b00;
    alu_srcA  = 1'b0;
    alu_srcB  = 2'b00;
    write_a   = 1'b0;
    write_b   = 1'b0;
    write_reg = 1'b0;
    case (state_q)
      S_IF: begin
        write_ir = 1'b1;
        write_pc = 1'b1;
        alu_srcB = 2'b01;
      end
      S_ID: begin
        write_a  = 1'b1;
        write_b  = 1'b1;
        write_c  = 1'b1;
        alu_srcB = 2'b11;
      end
      S_MADDR: begin
        alu_srcA = 1'b1;
        alu_srcB = 2'b10;
        write_c  = 1'b1;
      end
      S_MRD: begin
        iord     = 1'b1;
        write_dr = 1'b1;
      end
      S_LWWB: begin
        write_reg = 1'b1;
        memtoreg  = 1'b1;
      end
      S_MWR: begin
        iord      = 1'b1;
        write_mem = 1'b1;
      end
      S_REX: begin
        alu_srcA = 1'b1;
        alu_ctrl = 2'b10;
        write_c  = 1'b1;
      end
      S_RWB: begin
        write_reg = 1'b1;
        regdst    = 1'b1;
      end
      S_BEQ: begin
        alu_srcA = 1'b1;
        alu_ctrl = 2'b01;
        pcsource = 2'b01;
        write_pc = zero;
      end
      S_J: begin
        pcsource = 2'b10;
        write_pc = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (state_q)
      S_IF:                       insn_stage = 3'd0;
      S_ID:                       insn_stage = 3'd1;
      S_MADDR, S_REX, S_BEQ, S_J: insn_stage = 3'd2;
      S_MRD, S_MWR:               insn_stage = 3'd3;
      S_LWWB, S_RWB:              insn_stage = 3'd4;
      default:                    insn_stage = 3'd0;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks each instruction class through its
// state sequence and checks the full control word, stage and decode outputs.
module tb_mc_ctrl;
  logic        clk, rst, zero;
  logic [31:0] ir_data;
  logic        write_pc, iord, write_mem, write_dr, write_ir, memtoreg, regdst;
  logic [1:0]  pcsource, alu_ctrl, alu_srcB;
  logic        write_c, alu_srcA, write_a, write_b, write_reg;
  logic [3:0]  state, insn_type, insn_code;
  logic [2:0]  insn_stage;

  int n_chk  = 0;
  int n_fail = 0;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .ir_data(ir_data), .zero(zero),
    .write_pc(write_pc), .iord(iord), .write_mem(write_mem),
    .write_dr(write_dr), .write_ir(write_ir), .memtoreg(memtoreg),
    .regdst(regdst), .pcsource(pcsource), .write_c(write_c),
    .alu_ctrl(alu_ctrl), .alu_srcA(alu_srcA), .alu_srcB(alu_srcB),
    .write_a(write_a), .write_b(write_b), .write_reg(write_reg),
    .state(state), .insn_type(insn_type), .insn_code(insn_code),
    .insn_stage(insn_stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field order: wpc iord wmem wdr wir m2r rdst pcsrc wc alu srcA srcB wa wb wreg
  localparam logic [17:0] C_IF    = 18'b1_0_0_0_1_0_0_00_0_00_0_01_0_0_0;
  localparam logic [17:0] C_ID    = 18'b0_0_0_0_0_0_0_00_1_00_0_11_1_1_0;
  localparam logic [17:0] C_MADDR = 18'b0_0_0_0_0_0_0_00_1_00_1_10_0_0_0;
  localparam logic [17:0] C_MRD   = 18'b0_1_0_1_0_0_0_00_0_00_0_00_0_0_0;
  localparam logic [17:0] C_LWWB  = 18'b0_0_0_0_0_1_0_00_0_00_0_00_0_0_1;
  localparam logic [17:0] C_MWR   = 18'b0_1_1_0_0_0_0_00_0_00_0_00_0_0_0;
  localparam logic [17:0] C_REX   = 18'b0_0_0_0_0_0_0_00_1_10_1_00_0_0_0;
  localparam logic [17:0] C_RWB   = 18'b0_0_0_0_0_0_1_00_0_00_0_00_0_0_1;
  localparam logic [17:0] C_BEQ1  = 18'b1_0_0_0_0_0_0_01_0_01_1_00_0_0_0;
  localparam logic [17:0] C_BEQ0  = 18'b0_0_0_0_0_0_0_01_0_01_1_00_0_0_0;
  localparam logic [17:0] C_J     = 18'b1_0_0_0_0_0_0_10_0_00_0_00_0_0_0;

  function automatic logic [17:0] ctl_word();
    return {write_pc, iord, write_mem, write_dr, write_ir, memtoreg, regdst,
            pcsource, write_c, alu_ctrl, alu_srcA, alu_srcB,
            write_a, write_b, write_reg};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then check state, stage and control word.
  task automatic step(input string tag, input int st, input int stg, input logic [17:0] c);
    @(posedge clk); #1;
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".stage"}, 32'(insn_stage), 32'(stg));
    chk({tag, ".ctl"},   32'(ctl_word()), 32'(c));
  endtask

  task automatic chk_dec(input string tag, input int t, input int c);
    chk({tag, ".type"}, 32'(insn_type), 32'(t));
    chk({tag, ".code"}, 32'(insn_code), 32'(c));
  endtask

  initial begin
    rst = 1'b1; zero = 1'b0; ir_data = 32'h8C010014;
    step("rst", 0, 0, C_IF);
    chk_dec("rst", 0, 0);
    rst = 1'b0;

    // lw: 5 cycles
    step("lw.id", 1, 1, C_ID);
    chk_dec("lw.id", 0, 0);
    step("lw.maddr", 2, 2, C_MADDR);
    chk_dec("lw.maddr", 2, 0);
    step("lw.mrd", 3, 3, C_MRD);
    step("lw.wb", 4, 4, C_LWWB);
    step("lw.if", 0, 0, C_IF);

    // add: 4 cycles
    ir_data = 32'h00221820;
    step("add.id", 1, 1, C_ID);
    step("add.rex", 6, 2, C_REX);
    chk_dec("add.rex", 1, 1);
    step("add.rwb", 7, 4, C_RWB);
    step("add.if", 0, 0, C_IF);
    chk_dec("add.if", 1, 1);

    // sw: decode stays from add until ID completes
    ir_data = 32'hAC060016;
    step("sw.id", 1, 1, C_ID);
    chk_dec("sw.id", 1, 1);
    step("sw.maddr", 2, 2, C_MADDR);
    step("sw.mwr", 5, 3, C_MWR);
    chk_dec("sw.mwr", 3, 0);
    step("sw.if", 0, 0, C_IF);

    // beq: write_pc follows zero combinationally
    ir_data = 32'h10220003; zero = 1'b1;
    step("beq.id", 1, 1, C_ID);
    step("beq.ex1", 8, 2, C_BEQ1);
    chk_dec("beq.ex", 4, 0);
    zero = 1'b0; #1;
    chk("beq.ex0.ctl", 32'(ctl_word()), 32'(C_BEQ0));
    step("beq.if", 0, 0, C_IF);

    // j: 3 cycles
    ir_data = 32'h08000000;
    step("j.id", 1, 1, C_ID);
    step("j.ex", 9, 2, C_J);
    chk_dec("j.ex", 5, 0);
    step("j.if", 0, 0, C_IF);

    // illegal opcode returns straight to IF
    ir_data = 32'hFC000000;
    step("ill.id", 1, 1, C_ID);
    step("ill.if", 0, 0, C_IF);
    chk_dec("ill.if", 0, 0);

    // unknown R funct still runs the R flow with code 0
    ir_data = 32'h00221821;
    step("ufn.id", 1, 1, C_ID);
    step("ufn.rex", 6, 2, C_REX);
    chk_dec("ufn.rex", 1, 0);
    step("ufn.rwb", 7, 4, C_RWB);
    step("ufn.if", 0, 0, C_IF);

    // nor decode
    ir_data = 32'h00221827;
    step("nor.id", 1, 1, C_ID);
    step("nor.rex", 6, 2, C_REX);
    chk_dec("nor.rex", 1, 5);
    step("nor.rwb", 7, 4, C_RWB);
    step("nor.if", 0, 0, C_IF);

    // reset during MRD aborts the load
    ir_data = 32'h8C010014;
    step("abt.id", 1, 1, C_ID);
    step("abt.maddr", 2, 2, C_MADDR);
    step("abt.mrd", 3, 3, C_MRD);
    rst = 1'b1;
    step("abt.rst", 0, 0, C_IF);
    chk("abt.write_dr", 32'(write_dr), 32'd0);
    chk_dec("abt.rst", 0, 0);
    rst = 1'b0;
    step("abt.id2", 1, 1, C_ID);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
